// File: rtl/pulse_frequency_classifier.sv
// Measures the period between rising edges of one synchronised pixel sample stream,
// classifies each period against two nominal frequencies and accumulates per-class time.
module pulse_frequency_classifier #(
  parameter int unsigned FREQUENCY0           = 32'd7500,
  parameter int unsigned FREQUENCY1           = 32'd10000,
  parameter int unsigned FREQUENCY0_DEVIATION = 32'd30,
  parameter int unsigned FREQUENCY1_DEVIATION = 32'd30,
  parameter int unsigned CLOCK_FREQUENCY      = 32'd100000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_data,
  output logic [31:0] f0_value,
  output logic [31:0] f1_value,
  output logic [31:0] unknown,
  output logic        period_valid,
  output logic [1:0]  period_class
);

  localparam logic [31:0] T0  = 32'(CLOCK_FREQUENCY / FREQUENCY0);
  localparam logic [31:0] LO0 = 32'((T0 * (32'd100 - FREQUENCY0_DEVIATION)) / 32'd100);
  localparam logic [31:0] HI0 = 32'((T0 * (32'd100 + FREQUENCY0_DEVIATION)) / 32'd100);
  localparam logic [31:0] T1  = 32'(CLOCK_FREQUENCY / FREQUENCY1);
  localparam logic [31:0] LO1 = 32'((T1 * (32'd100 - FREQUENCY1_DEVIATION)) / 32'd100);
  localparam logic [31:0] HI1 = 32'((T1 * (32'd100 + FREQUENCY1_DEVIATION)) / 32'd100);
  localparam logic [31:0] SAT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    CLS_F0  = 2'd0,
    CLS_F1  = 2'd1,
    CLS_UNK = 2'd2
  } class_e;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[32]) begin
      sat_add = SAT;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  logic        s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic        armed_q, armed_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] p_q, p_d;
  logic        cap_q, cap_d;
  logic [31:0] f0_q, f0_d, f1_q, f1_d, unk_q, unk_d;
  logic        valid_q, valid_d;
  class_e      class_q, class_d;
  logic        rise_s, in0_s, in1_s;
  class_e      cls_s;

  // Classify the captured period; overlapping windows resolve to the nearer nominal, ties to f0.
  always_comb begin
    rise_s = s2_q & ~prev_q;
    in0_s  = (p_q >= LO0) && (p_q <= HI0);
    in1_s  = (p_q >= LO1) && (p_q <= HI1);
    cls_s  = CLS_UNK;
    if (in0_s && in1_s) begin
      if (abs_diff(p_q, T0) <= abs_diff(p_q, T1)) begin
        cls_s = CLS_F0;
      end else begin
        cls_s = CLS_F1;
      end
    end else if (in0_s) begin
      cls_s = CLS_F0;
    end else if (in1_s) begin
      cls_s = CLS_F1;
    end else begin
      cls_s = CLS_UNK;
    end
  end

  // Next-state logic: synchroniser, arming, period counter, capture and accumulation.
  always_comb begin
    s1_d    = sample_data;
    s2_d    = s1_q;
    prev_d  = s2_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    cap_d   = 1'b0;
    f0_d    = f0_q;
    f1_d    = f1_q;
    unk_d   = unk_q;
    valid_d = 1'b0;
    class_d = class_q;

    if (!enable) begin
      armed_d = 1'b0;
      cnt_d   = 32'd0;
    end else if (rise_s) begin
      armed_d = 1'b1;
      cnt_d   = 32'd1;
      if (armed_q) begin
        p_d   = cnt_q;
        cap_d = 1'b1;
      end else begin
        cap_d = 1'b0;
      end
    end else if (armed_q) begin
      if (cnt_q != SAT) begin
        cnt_d = cnt_q + 32'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end

    // A period still in the classification stage is dropped if enable has fallen.
    if (enable && cap_q) begin
      valid_d = 1'b1;
      class_d = cls_s;
      case (cls_s)
        CLS_F0:  f0_d  = sat_add(f0_q, p_q);
        CLS_F1:  f1_d  = sat_add(f1_q, p_q);
        CLS_UNK: unk_d = p_q;
        default: unk_d = p_q;
      endcase
    end else begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= 32'd0;
      p_q     <= 32'd0;
      cap_q   <= 1'b0;
      f0_q    <= 32'd0;
      f1_q    <= 32'd0;
      unk_q   <= 32'd0;
      valid_q <= 1'b0;
      class_q <= CLS_F0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      cap_q   <= cap_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      unk_q   <= unk_d;
      valid_q <= valid_d;
      class_q <= class_d;
    end
  end

  assign f0_value     = f0_q;
  assign f1_value     = f1_q;
  assign unknown      = unk_q;
  assign period_valid = valid_q;
  assign period_class = class_q;

endmodule

// File: tb/tb_pulse_frequency_classifier.sv
// Directed bench for pulse_frequency_classifier at a 1 MHz clock setting:
// T0=133 (93..172), T1=100 (70..130), overlap resolves at 116/117.
module tb_pulse_frequency_classifier;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        sample_data;
  logic [31:0] f0_value;
  logic [31:0] f1_value;
  logic [31:0] unknown;
  logic        period_valid;
  logic [1:0]  period_class;

  int          checks;
  int          errors;
  int          vcount;
  logic [1:0]  last_class;
  logic [31:0] exp_f0;
  logic [31:0] exp_f1;
  logic [31:0] exp_unk;

  pulse_frequency_classifier #(
    .FREQUENCY0          (32'd7500),
    .FREQUENCY1          (32'd10000),
    .FREQUENCY0_DEVIATION(32'd30),
    .FREQUENCY1_DEVIATION(32'd30),
    .CLOCK_FREQUENCY     (32'd1000000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sample_data (sample_data),
    .f0_value    (f0_value),
    .f1_value    (f1_value),
    .unknown     (unknown),
    .period_valid(period_valid),
    .period_class(period_class)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (period_valid === 1'b1) begin
      vcount     <= vcount + 1;
      last_class <= period_class;
    end
  end

  // One rise, then the next rise of the stream comes exactly p clocks later.
  task automatic pulse(input int p);
    sample_data = 1'b1;
    repeat (p / 2) @(posedge clock);
    #1;
    sample_data = 1'b0;
    repeat (p - p / 2) @(posedge clock);
    #1;
  endtask

  task automatic rearm();
    enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sample_data = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks += 5;
    if (f0_value !== 32'd0) begin errors++; $display("FAIL reset_f0 got %0d exp 0", f0_value); end
    if (f1_value !== 32'd0) begin errors++; $display("FAIL reset_f1 got %0d exp 0", f1_value); end
    if (unknown !== 32'd0) begin errors++; $display("FAIL reset_unk got %0d exp 0", unknown); end
    if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", period_valid); end
    if (period_class !== 2'd0) begin errors++; $display("FAIL reset_class got %0d exp 0", period_class); end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_f0();
    int v0;
    rearm();
    v0 = vcount;
    pulse(133);
    for (int i = 0; i < 4; i++) begin
      pulse(133);
      checks++;
      if (last_class !== 2'd0) begin errors++; $display("FAIL f0_class[%0d] got %0d exp 0", i, last_class); end
    end
    exp_f0 = 32'd532;
    checks += 3;
    if (vcount - v0 !== 4) begin errors++; $display("FAIL f0_count got %0d exp 4", vcount - v0); end
    if (f0_value !== exp_f0) begin errors++; $display("FAIL f0_value got %0d exp %0d", f0_value, exp_f0); end
    if (f1_value !== exp_f1) begin errors++; $display("FAIL f0_f1hold got %0d exp %0d", f1_value, exp_f1); end
  endtask

  task automatic test_f1();
    int v0;
    rearm();
    v0 = vcount;
    repeat (3) pulse(100);
    exp_f1 = 32'd200;
    checks += 4;
    if (vcount - v0 !== 2) begin errors++; $display("FAIL f1_count got %0d exp 2", vcount - v0); end
    if (last_class !== 2'd1) begin errors++; $display("FAIL f1_class got %0d exp 1", last_class); end
    if (f1_value !== exp_f1) begin errors++; $display("FAIL f1_value got %0d exp %0d", f1_value, exp_f1); end
    if (f0_value !== exp_f0) begin errors++; $display("FAIL f1_f0hold got %0d exp %0d", f0_value, exp_f0); end
  endtask

  task automatic test_unknown();
    rearm();
    pulse(50);
    pulse(200);
    checks += 2;
    if (unknown !== 32'd50) begin errors++; $display("FAIL unk_50 got %0d exp 50", unknown); end
    if (last_class !== 2'd2) begin errors++; $display("FAIL unk_class got %0d exp 2", last_class); end
    pulse(20);
    exp_unk = 32'd200;
    checks += 3;
    if (unknown !== exp_unk) begin errors++; $display("FAIL unk_200 got %0d exp %0d", unknown, exp_unk); end
    if (f0_value !== exp_f0) begin errors++; $display("FAIL unk_f0hold got %0d exp %0d", f0_value, exp_f0); end
    if (f1_value !== exp_f1) begin errors++; $display("FAIL unk_f1hold got %0d exp %0d", f1_value, exp_f1); end
  endtask

  task automatic test_overlap();
    rearm();
    pulse(116);
    pulse(117);
    exp_f1 = 32'd316;
    checks += 2;
    if (last_class !== 2'd1) begin errors++; $display("FAIL ovl_116_class got %0d exp 1", last_class); end
    if (f1_value !== exp_f1) begin errors++; $display("FAIL ovl_116_f1 got %0d exp %0d", f1_value, exp_f1); end
    pulse(20);
    exp_f0 = 32'd649;
    checks += 2;
    if (last_class !== 2'd0) begin errors++; $display("FAIL ovl_117_class got %0d exp 0", last_class); end
    if (f0_value !== exp_f0) begin errors++; $display("FAIL ovl_117_f0 got %0d exp %0d", f0_value, exp_f0); end
  endtask

  task automatic test_boundaries();
    int         per [5];
    logic [1:0] cls [5];
    per = '{69, 70, 172, 173, 131};
    cls = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd0};
    rearm();
    pulse(per[0]);
    for (int i = 0; i < 5; i++) begin
      pulse((i < 4) ? per[i + 1] : 10);
      if (cls[i] == 2'd0) exp_f0 = exp_f0 + 32'(per[i]);
      else if (cls[i] == 2'd1) exp_f1 = exp_f1 + 32'(per[i]);
      else exp_unk = 32'(per[i]);
      checks += 4;
      if (last_class !== cls[i]) begin errors++; $display("FAIL bnd_class[%0d] got %0d exp %0d", per[i], last_class, cls[i]); end
      if (f0_value !== exp_f0) begin errors++; $display("FAIL bnd_f0[%0d] got %0d exp %0d", per[i], f0_value, exp_f0); end
      if (f1_value !== exp_f1) begin errors++; $display("FAIL bnd_f1[%0d] got %0d exp %0d", per[i], f1_value, exp_f1); end
      if (unknown !== exp_unk) begin errors++; $display("FAIL bnd_unk[%0d] got %0d exp %0d", per[i], unknown, exp_unk); end
    end
  endtask

  task automatic test_enable_drop();
    int v0;
    rearm();
    pulse(133);
    pulse(133);
    exp_f0 = exp_f0 + 32'd133;
    sample_data = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    enable = 1'b0;
    v0 = vcount;
    repeat (60) @(posedge clock);
    #1;
    sample_data = 1'b0;
    repeat (60) @(posedge clock);
    #1;
    repeat (4) pulse(133);
    checks += 3;
    if (vcount !== v0) begin errors++; $display("FAIL dis_novalid got %0d exp %0d", vcount, v0); end
    if (f0_value !== exp_f0) begin errors++; $display("FAIL dis_f0hold got %0d exp %0d", f0_value, exp_f0); end
    if (f1_value !== exp_f1) begin errors++; $display("FAIL dis_f1hold got %0d exp %0d", f1_value, exp_f1); end
    enable = 1'b1;
    pulse(133);
    checks++;
    if (vcount !== v0) begin errors++; $display("FAIL reen_armonly got %0d exp %0d", vcount, v0); end
    pulse(133);
    exp_f0 = exp_f0 + 32'd133;
    checks += 2;
    if (vcount !== v0 + 1) begin errors++; $display("FAIL reen_valid got %0d exp %0d", vcount, v0 + 1); end
    if (f0_value !== exp_f0) begin errors++; $display("FAIL reen_f0 got %0d exp %0d", f0_value, exp_f0); end
  endtask

  task automatic test_reset_mid();
    int v0;
    pulse(133);
    exp_f0 = exp_f0 + 32'd133;
    checks++;
    if (f0_value !== exp_f0) begin errors++; $display("FAIL rst_pre_f0 got %0d exp %0d", f0_value, exp_f0); end
    sample_data = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    v0 = vcount;
    @(posedge clock);
    #1;
    checks += 5;
    if (period_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", period_valid); end
    if (f0_value !== 32'd0) begin errors++; $display("FAIL rst_f0 got %0d exp 0", f0_value); end
    if (f1_value !== 32'd0) begin errors++; $display("FAIL rst_f1 got %0d exp 0", f1_value); end
    if (unknown !== 32'd0) begin errors++; $display("FAIL rst_unk got %0d exp 0", unknown); end
    if (period_class !== 2'd0) begin errors++; $display("FAIL rst_class got %0d exp 0", period_class); end
    reset = 1'b0;
    sample_data = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    pulse(40);
    checks++;
    if (vcount !== v0) begin errors++; $display("FAIL rst_armonly got %0d exp %0d", vcount, v0); end
    sample_data = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (period_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %0b exp 0", period_valid); end
    @(posedge clock);
    #1;
    checks += 3;
    if (period_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %0b exp 1", period_valid); end
    if (period_class !== 2'd2) begin errors++; $display("FAIL lat_class got %0d exp 2", period_class); end
    if (unknown !== 32'd40) begin errors++; $display("FAIL lat_unk got %0d exp 40", unknown); end
    @(posedge clock);
    #1;
    checks++;
    if (period_valid !== 1'b0) begin errors++; $display("FAIL lat_onecycle got %0b exp 0", period_valid); end
    sample_data = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; vcount = 0; last_class = 2'd0;
    exp_f0 = 32'd0; exp_f1 = 32'd0; exp_unk = 32'd0;
    reset = 1'b1; enable = 1'b0; sample_data = 1'b0;
    test_reset();
    test_f0();
    test_f1();
    test_unknown();
    test_overlap();
    test_boundaries();
    test_enable_drop();
    test_reset_mid();
    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
